// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns HI/LO and stalls EX through busy.
// Define MULDIV_FAST_MUL_EN to finish multiplies in the start cycle with a single-cycle multiplier.
module muldiv_ctrl #(
    parameter logic [31:0] HILO_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  op_q;
    logic [31:0] opnd;
    logic [63:0] acc;
    logic [31:0] rem;
    logic        sign_q, sign_r;
    logic [4:0]  count;
    logic [31:0] hi_q, lo_q;

    logic        is_signed, accept, div_by_zero, short_op;
    logic [31:0] mag1, mag2;

    assign is_signed   = ~op[0];
    assign mag1        = (is_signed && num1[31]) ? -num1 : num1;
    assign mag2        = (is_signed && num2[31]) ? -num2 : num2;
    assign accept      = (state == IDLE) && start && !flush;
    assign div_by_zero = op[1] && (num2 == 32'd0);

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] fast_prod;
    assign fast_prod = op[0] ? ({32'd0, num1} * {32'd0, num2})
                             : $unsigned($signed({{32{num1[31]}}, num1}) *
                                         $signed({{32{num2[31]}}, num2}));
    assign short_op  = div_by_zero || !op[1];
`else
    assign short_op  = div_by_zero;
`endif

    // One 33-bit adder: adds the multiplicand for shift-add, subtracts the divisor for restoring division.
    // For multiply acc holds {partial product, remaining multiplier}; for divide acc[31:0] shifts dividend out / quotient in.
    logic        calc_mul, q_bit;
    logic [32:0] shifted, add_a, add_y;
    logic [31:0] add_b, rem_nxt;
    logic [63:0] acc_nxt;

    assign calc_mul = ~op_q[1];
    assign shifted  = {rem, acc[31]};
    assign add_a    = calc_mul ? {1'b0, acc[63:32]} : shifted;
    assign add_b    = (calc_mul && !acc[0]) ? 32'd0 : opnd;
    assign add_y    = calc_mul ? (add_a + {1'b0, add_b}) : (add_a - {1'b0, add_b});
    assign q_bit    = ~add_y[32];
    assign acc_nxt  = calc_mul ? {add_y, acc[31:1]} : {acc[63:32], acc[30:0], q_bit};
    assign rem_nxt  = calc_mul ? rem : (q_bit ? add_y[31:0] : shifted[31:0]);

    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign prod_fix = sign_q ? -acc_nxt : acc_nxt;
    assign quo_fix  = sign_q ? -acc_nxt[31:0] : acc_nxt[31:0];
    assign rem_fix  = sign_r ? -rem_nxt : rem_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    busy      = 1'b1;
                    state_nxt = short_op ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (count == 5'd31) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    // A flush only clears the counter; the abandoned operands are harmless since HI/LO are not touched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= 2'b00;
            opnd   <= 32'd0;
            acc    <= 64'd0;
            rem    <= 32'd0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            count  <= 5'd0;
            hi_q   <= HILO_RST;
            lo_q   <= HILO_RST;
        end else if (flush) begin
            count <= 5'd0;
        end else if (accept) begin
            op_q   <= op;
            sign_q <= is_signed & (num1[31] ^ num2[31]);
            sign_r <= is_signed & num1[31];
            opnd   <= op[1] ? mag2 : mag1;
            acc    <= {32'd0, (op[1] ? mag1 : mag2)};
            rem    <= 32'd0;
            count  <= 5'd0;
            if (div_by_zero) begin
                lo_q <= 32'hFFFF_FFFF;
                hi_q <= num1;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!op[1]) begin
                hi_q <= fast_prod[63:32];
                lo_q <= fast_prod[31:0];
            end
`endif
        end else if (state == CALC) begin
            count <= count + 5'd1;
            acc   <= acc_nxt;
            rem   <= rem_nxt;
            if (count == 5'd31) begin
                if (calc_mul) begin
                    hi_q <= prod_fix[63:32];
                    lo_q <= prod_fix[31:0];
                end else begin
                    hi_q <= rem_fix;
                    lo_q <= quo_fix;
                end
            end
        end else if (state == IDLE) begin
            if (hi_we) begin
                hi_q <= wdata;
            end
            if (lo_we) begin
                lo_q <= wdata;
            end
        end
    end

    assign done   = (state == DONE);
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized and directed bench for muldiv_ctrl against a plain-arithmetic HI/LO and latency model.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_ctrl;

    localparam logic [31:0] HILO = 32'h0BAD_F00D;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] num1, num2, wdata;
    logic        busy, done;
    logic [31:0] hi_out, lo_out;

    int errors = 0;
    int checks = 0;

    muldiv_ctrl #(.HILO_RST(HILO)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .num1(num1), .num2(num2),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // MIPS semantics: signed divide truncates toward zero, remainder takes the dividend's sign.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
        longint sa, sb, p, q, r;
        logic [63:0] u;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            2'd0: begin p = sa * sb; u = p; eh = u[63:32]; el = u[31:0]; end
            2'd1: begin u = {32'd0, a} * {32'd0, b}; eh = u[63:32]; el = u[31:0]; end
            2'd2: begin
                if (b == 32'd0) begin eh = a; el = 32'hFFFF_FFFF; end
                else begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
            end
            default: begin
                if (b == 32'd0) begin eh = a; el = 32'hFFFF_FFFF; end
                else begin el = a / b; eh = a % b; end
            end
        endcase
    endtask

    task automatic mtWrite(input bit to_hi, input logic [31:0] d);
        @(negedge clk); #1;
        wdata = d;
        if (to_hi) hi_we = 1'b1; else lo_we = 1'b1;
        @(negedge clk); #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        checkOutput(to_hi ? "mthi" : "mtlo", to_hi ? hi_out : lo_out, d);
    endtask

    // Holds start through DONE like a stalled EX instruction; optional flush or hi_we at a given cycle.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input int flush_at, input int we_at);
        logic [31:0] eh, el, hi0, lo0;
        int busy_cnt, done_at, exp_lat;
        bit aborted;
        model(o, a, b, eh, el);
        exp_lat = (o[1] && b == 32'd0) ? 1 : 33;
`ifdef MULDIV_FAST_MUL_EN
        if (!o[1]) exp_lat = 1;
`endif
        aborted = 1'b0;
        done_at = 0;
        @(negedge clk); #1;
        hi0 = hi_out; lo0 = lo_out;
        op = o; num1 = a; num2 = b; start = 1'b1;
        #1;
        busy_cnt = int'(busy);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk); #1;
            if (hi_we) begin
                hi_we = 1'b0;
                checkOutput("hi_we_ignored", hi_out, hi0);
            end
            if (flush) begin
                flush = 1'b0;
                checkOutput("flush_busy", busy, 0);
                checkOutput("flush_done", done, 0);
                checkOutput("flush_hi", hi_out, hi0);
                checkOutput("flush_lo", lo_out, lo0);
                aborted = 1'b1;
            end else if (done) begin
                done_at = k;
                checkOutput("hi", hi_out, eh);
                checkOutput("lo", lo_out, el);
            end else begin
                busy_cnt += int'(busy);
                if (k == flush_at) begin flush = 1'b1; start = 1'b0; end
                if (k == we_at) begin hi_we = 1'b1; wdata = ~hi0; end
            end
            if (aborted || done_at != 0) break;
        end
        if (!aborted) begin
            if (done_at == 0) begin
                checkOutput("timeout", 0, 1);
                start = 1'b0;
            end else begin
                checkOutput("done_cycle", done_at, exp_lat);
                checkOutput("busy_cycles", busy_cnt, exp_lat);
                @(negedge clk); #1;
                start = 1'b0;
                #1;
                checkOutput("no_restart", {busy, done}, 0);
            end
        end
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'd0; num1 = 32'd0; num2 = 32'd0; wdata = 32'd0;
        #2;
        checkOutput("rst_hi", hi_out, HILO);
        checkOutput("rst_lo", lo_out, HILO);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0);
        applyStimulus(2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 0, 0);
        applyStimulus(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
        applyStimulus(2'd3, 32'd100, 32'd7, 0, 0);
        applyStimulus(2'd3, 32'h1234_5678, 32'd0, 0, 0);
        applyStimulus(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);

        mtWrite(1'b1, 32'hAAAA_AAAA);
        mtWrite(1'b0, 32'h5555_5555);
        applyStimulus(2'd2, 32'd1000, 32'd7, 10, 0);
        applyStimulus(2'd2, 32'd1000, 32'd7, 0, 0);
        mtWrite(1'b1, 32'hDEAD_BEEF);
        applyStimulus(2'd3, 32'hCAFE_0000, 32'd3, 0, 5);

        // flush and start together: flush wins, nothing starts
        @(negedge clk); #1;
        op = 2'd1; num1 = 32'd5; num2 = 32'd6; start = 1'b1; flush = 1'b1;
        #1;
        checkOutput("flush_start_busy", busy, 0);
        @(negedge clk); #1;
        start = 1'b0; flush = 1'b0;
        #1;
        checkOutput("flush_start_idle", {busy, done}, 0);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = -ra;
                default: ;
            endcase
            applyStimulus(ro, ra, rb, 0, 0);
        end

        // asynchronous reset in the middle of a long divide
        @(negedge clk); #1;
        op = 2'd3; num1 = 32'h7777_7777; num2 = 32'd9; start = 1'b1;
        repeat (15) @(negedge clk);
        #2;
        start = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_hi", hi_out, HILO);
        checkOutput("async_rst_lo", lo_out, HILO);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(2'd0, 32'h8000_0000, 32'h8000_0000, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer next to the EX-stage ALU; owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU iteratively over one shared 32-bit add/sub datapath.
- Stalls the pipeline through `busy` while it runs, and also handles MTHI/MTLO writes.
- Aborts cleanly on exception flush.

Parameters:
- HILO_RST, 32'h0000_0000, reset value of HI and LO.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  EX-stage mul/div instruction is valid.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- num1  in  32  rs operand (multiplicand or dividend).
- num2  in  32  rt operand (multiplier or divisor).
- flush  in  1  exception/ERET flush; aborts the current operation.
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- wdata  in  32  MTHI/MTLO data.
- busy  out  1  pipeline stall request.
- done  out  1  one-cycle completion pulse.
- hi_out  out  32  HI register.
- lo_out  out  32  LO register.

Behaviour:
- Reset (asynchronous): state=IDLE, HI=LO=HILO_RST, count=0, busy=0, done=0.
- States: IDLE, CALC, DONE.
- busy is combinational: 1 when (state==IDLE && start && !flush) or state==CALC. It is 0 in DONE.
- done is registered: 1 only in DONE.
- IDLE, start && !flush:
  - Latch op.
  - Signed ops latch |num1| and |num2| and record sign_q=num1[31]^num2[31] and sign_r=num1[31]. Unsigned ops latch raw values with both signs 0.
  - count=0.
  - Next state: CALC, except DIV/DIVU with num2==0, which goes straight to DONE and writes LO=32'hFFFF_FFFF, HI=num1.
- CALC, multiply: shift-add, one multiplier bit per cycle, 64-bit accumulator.
- CALC, divide: restoring division, 33-bit partial remainder, one quotient bit per cycle.
- CALC sequencing: count increments every cycle. On the edge ending count==31:
  - Apply sign fix-up: product negated if sign_q; quotient negated if sign_q; remainder negated if sign_r.
  - Write HI/LO. Multiply: HI=product[63:32], LO=product[31:0]. Divide: HI=remainder, LO=quotient.
  - Next state: DONE.
- Latency: start seen in cycle 0; CALC occupies cycles 1..32; HI/LO are visible in cycle 33 (DONE). busy is high for cycles 0..32 (33 cycles).
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE, because the originating instruction is still in EX while it leaves.
- MTHI/MTLO: in IDLE, hi_we/lo_we write wdata at the clock edge. Ignored in CALC/DONE.
- start and hi_we/lo_we together in IDLE: start is accepted and the MT write is dropped.
- flush in any state: next state IDLE, HI/LO unchanged, no done pulse, count cleared.
- flush and start together in IDLE: flush wins, busy=0.
- Signed overflow case 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0, no trap.
- Unsigned arithmetic is used throughout on the magnitudes; there are no overflow outputs.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU compute the 64-bit product in the start cycle with a single-cycle multiplier.
  - HI/LO are written on that edge and the state goes IDLE->DONE.
  - busy is high 1 cycle and done pulses in cycle 1.
  - Divides are unchanged.
- Undefined: multiplies use the 32-cycle shift-add path described above.

Test Plan:
- MULTU num1=0xFFFF_FFFF, num2=0x0000_0002 -> busy high 33 cycles, done in cycle 33, HI=0x0000_0001, LO=0xFFFF_FFFE. With MULDIV_FAST_MUL_EN: busy 1 cycle, done in cycle 1.
- MULT num1=0xFFFF_FFFD (-3), num2=0x0000_0007 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFEB (-21).
- DIV num1=0xFFFF_FFF9 (-7), num2=2 -> LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1). DIVU 100/7 -> LO=14, HI=2.
- DIVU num1=0x1234_5678, num2=0 -> DONE in cycle 1, LO=0xFFFF_FFFF, HI=0x1234_5678.
- DIV started, flush asserted in cycle 10 -> busy=0 next cycle, no done, HI/LO keep their prior values (e.g. 0xAAAA_AAAA/0x5555_5555). A new start the cycle after runs a full 33 cycles.
- MTHI wdata=0xDEAD_BEEF in IDLE -> hi_out=0xDEAD_BEEF next cycle. hi_we during CALC -> ignored. start held high through DONE -> no second operation. Async rst mid-CALC -> HI=LO=HILO_RST, busy=0 immediately.
